// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detectors.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 16;
    localparam int PAT_IDX_W   = $clog2(PAT_LEN_MAX);

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input logic [PAT_LEN_MAX-1:0] pattern,
                                     input int len, input int i);
        return pattern[PAT_IDX_W'(len - 1 - i)];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(input logic [PAT_LEN_MAX-1:0] pattern, input int len);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < len; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pat_bit(pattern, len, i) != pat_bit(pattern, len, len - k + i)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    // Matched-prefix length after appending b to a matched prefix of length s.
    // Returns len when the full pattern has just been completed.
    function automatic int next_state(input logic [PAT_LEN_MAX-1:0] pattern, input int len,
                                      input int s, input logic b);
        int   res;
        logic ok;
        logic c;
        res = 0;
        for (int k = 1; k <= len; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    // Received sequence is the s-bit prefix followed by b
                    c = (s + 1 - k + i < s) ? pat_bit(pattern, len, s + 1 - k + i) : b;
                    if (c != pat_bit(pattern, len, i)) ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_ns_table.sv
// Combinational (state, bit) -> (next state, hit) lookup built at elaboration time.
module seq_det_ns_table
    import seq_det_pkg::*;
#(
    parameter int unsigned              PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]       PATTERN = 4'b0110,
    parameter int unsigned              OVERLAP = 0,
    localparam int                      SW      = $clog2(PAT_LEN)
) (
    input  logic [SW-1:0] state_i,
    input  logic          bit_i,
    output logic [SW-1:0] state_o,
    output logic          hit_o
);

    localparam logic [PAT_LEN_MAX-1:0] PAT_EXT = PAT_LEN_MAX'(PATTERN);
    localparam int                     BORDER  = border_len(PAT_EXT, PAT_LEN);
    localparam int                     ENTRIES = 2 ** (SW + 1);

    logic [SW-1:0] tbl_ns  [ENTRIES];
    logic          tbl_hit [ENTRIES];

    // One entry per {state, bit}; unreachable states map to 0 with no hit.
    for (genvar idx = 0; idx < ENTRIES; idx++) begin : g_tbl
        localparam int   S   = idx / 2;
        localparam logic B   = 1'(idx % 2);
        localparam int   NS  = (S < int'(PAT_LEN)) ? next_state(PAT_EXT, PAT_LEN, S, B) : 0;
        localparam bit   HIT = (NS == int'(PAT_LEN));
        localparam int   SN  = HIT ? ((OVERLAP != 0) ? BORDER : 0) : NS;
        assign tbl_ns[idx]  = SW'(SN);
        assign tbl_hit[idx] = HIT;
    end

    assign state_o = tbl_ns[{state_i, bit_i}];
    assign hit_o   = tbl_hit[{state_i, bit_i}];

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with registered match pulse and saturating counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
    parameter int unsigned        OVERLAP = 0,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               SW      = $clog2(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN must be within 2..16");
    end

    logic [SW-1:0]    state_q, state_d, state_tbl;
    logic             hit;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    seq_det_ns_table #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_ns_table (
        .state_i (state_q),
        .bit_i   (in),
        .state_o (state_tbl),
        .hit_o   (hit)
    );

    // Advance only on qualified bits; clear overrides a simultaneous match for the counter.
    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid) begin
            state_d = state_tbl;
            out_d   = hit;
            if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (cnt_clr) cnt_d = '0;
    end

    // State, pulse and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign match_cnt = cnt_q;

endmodule
